// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter and its watchdog.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // Owner of the most recent grant, used to alternate ties
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Default watchdog limit in unacknowledged memory cycles
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Saturating bus watchdog: counts enabled cycles since the last clear.
// Latency: expire is combinational, high in the cycle whose count step would reach TIMEOUT.
// Backpressure: none; the owner decides what to do with expire.
// Ports: clk/rstn clock and async active-low reset; clear zeroes the count
// (wins over enable); enable counts one cycle; expire flags the limit cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expire when this enabled cycle would bring the count to TIMEOUT.
    assign expire = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
            // Saturate rather than wrap so a stuck enable never re-arms.
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D).
// Latency: gnt combinational in IDLE; m_req next cycle; rvalid the cycle after m_ack.
// Backpressure: one transaction in flight; requesters hold req until gnt, gnt is 0 while busy.
// Ports: i_* fetch requester, d_* data requester, m_* memory side,
// busy = not IDLE, err = sticky watchdog trap (terminal until rstn).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              err
);

    logic [1:0]        state_q,      state_d;
    logic              last_owner_q, last_owner_d;
    logic              m_req_q,      m_req_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [3:0]        m_we_q,       m_we_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic              i_rvalid_q,   i_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic              d_rvalid_q,   d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

    logic              st_idle;
    logic              st_busy;
    logic              tmo_expire;
    logic [DATA_W-1:0] cpl_data;

    assign st_idle = (state_q == ST_IDLE);
    assign st_busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

    // Ties go to whoever did not own the previous grant.
    assign i_gnt = st_idle && i_req && (!d_req || (last_owner_q == OWN_D));
    assign d_gnt = st_idle && d_req && (!i_req || (last_owner_q == OWN_I));

    // Writes return zero data rather than whatever the memory drives.
    assign cpl_data = (m_we_q != 4'd0) ? '0 : m_rdata;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (i_gnt || d_gnt),
        .enable (st_busy && !m_ack),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        m_req_d      = m_req_q;
        m_addr_d     = m_addr_q;
        m_we_d       = m_we_q;
        m_wdata_d    = m_wdata_q;
        i_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (i_gnt) begin
                    m_addr_d     = i_addr;
                    m_we_d       = 4'd0;
                    m_wdata_d    = '0;
                    m_req_d      = 1'b1;
                    last_owner_d = OWN_I;
                    state_d      = ST_BUSY_I;
                end else if (d_gnt) begin
                    m_addr_d     = d_addr;
                    m_we_d       = d_we;
                    m_wdata_d    = d_wdata;
                    m_req_d      = 1'b1;
                    last_owner_d = OWN_D;
                    state_d      = ST_BUSY_D;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                // An ack in the expiry cycle still completes normally.
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = ST_IDLE;
                    if (state_q == ST_BUSY_I) begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = cpl_data;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = cpl_data;
                    end
                end else if (tmo_expire) begin
                    m_req_d = 1'b0;
                    state_d = ST_ERR;
                end
            end
            default: begin
                // ERR: terminal, owner never completes.
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_D;
            m_req_q      <= 1'b0;
            m_addr_q     <= '0;
            m_we_q       <= 4'd0;
            m_wdata_q    <= '0;
            i_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_we_q       <= m_we_d;
            m_wdata_q    <= m_wdata_d;
            i_rvalid_q   <= i_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_addr   = m_addr_q;
    assign m_we     = m_we_q;
    assign m_wdata  = m_wdata_q;
    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = !st_idle;
    assign err      = (state_q == ST_ERR);

endmodule
